vh_expr_eval_seq: RTL and testbench

- Parametrised, handshaked evaluator for the Verilog binary operators whose width, signedness and undef semantics the team's expression tests exercise.
- Sits in the self-check harness as the golden model. It receives an operator code and two operands, computes the result under IEEE 1364-2005 context-width and signedness rules, and returns it with an undef flag.
- Single-cycle operators complete in one cycle. DIV, MOD and POW run as multi-cycle iterative engines.

---
 rtl/vh_expr_pkg.sv | 35 +++
 rtl/vh_iter_engine.sv | 77 +++++++
 rtl/vh_expr_eval_seq.sv | 201 ++++++++++++++++++++
 tb/tb_vh_expr_eval_seq.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/vh_expr_pkg.sv
// Shared types and helpers for the Verilog expression evaluator.
package vh_expr_pkg;

  typedef enum logic [3:0] {
    OpAdd  = 4'd0,
    OpSub  = 4'd1,
    OpMul  = 4'd2,
    OpDiv  = 4'd3,
    OpMod  = 4'd4,
    OpPow  = 4'd5,
    OpShl  = 4'd6,
    OpShr  = 4'd7,
    OpSshr = 4'd8,
    OpAnd  = 4'd9,
    OpOr   = 4'd10,
    OpXor  = 4'd11,
    OpXnor = 4'd12,
    OpLt   = 4'd13,
    OpEq   = 4'd14
  } op_t;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_t;

  function automatic int unsigned max3(input int unsigned x, input int unsigned y,
                                       input int unsigned z);
    int unsigned m;
    m = (x > y) ? x : y;
    return (m > z) ? m : z;
  endfunction

endpackage

// File: rtl/vh_iter_engine.sv
// Shared iterative datapath: restoring divider on magnitudes (W steps) or
// MSB-first square-and-multiply modulo 2^W (EW steps). Results valid while done_o is high.
module vh_iter_engine #(
  parameter int unsigned W  = 8,
  parameter int unsigned EW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          pow_i,
  input  logic [W-1:0]  opa_i,
  input  logic [W-1:0]  opb_i,
  input  logic [EW-1:0] exp_i,
  output logic          done_o,
  output logic [W-1:0]  quot_o,
  output logic [W-1:0]  rem_o,
  output logic [W-1:0]  pow_o
);

  localparam int unsigned CntW = $clog2(W + 1);

  logic            busy_q, pow_q;
  logic [CntW-1:0] cnt_q;
  logic [W-1:0]    x_q, r_q, d_q;
  logic [EW-1:0]   e_q;
  logic [W-1:0]    x_d, r_d, sq;
  logic [W:0]      r_sh, r_sub;

  always_comb begin
    r_sh  = {r_q, x_q[W-1]};
    r_sub = r_sh - {1'b0, d_q};
    sq    = x_q * x_q;
    if (pow_q) begin
      x_d = e_q[EW-1] ? sq * d_q : sq;
      r_d = r_q;
    end else if (!r_sub[W]) begin
      // No borrow: shifted remainder covers the divisor.
      x_d = {x_q[W-2:0], 1'b1};
      r_d = r_sub[W-1:0];
    end else begin
      x_d = {x_q[W-2:0], 1'b0};
      r_d = r_sh[W-1:0];
    end
  end

  assign done_o = busy_q && (cnt_q == '0);
  assign quot_o = x_d;
  assign rem_o  = r_d;
  assign pow_o  = x_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      pow_q  <= 1'b0;
      cnt_q  <= '0;
      x_q    <= '0;
      r_q    <= '0;
      d_q    <= '0;
      e_q    <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      pow_q  <= pow_i;
      cnt_q  <= pow_i ? CntW'(EW - 1) : CntW'(W - 1);
      x_q    <= pow_i ? W'(1) : opa_i;
      d_q    <= pow_i ? opa_i : opb_i;
      r_q    <= '0;
      e_q    <= exp_i;
    end else if (busy_q) begin
      x_q   <= x_d;
      r_q   <= r_d;
      e_q   <= e_q << 1;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == '0) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/vh_expr_eval_seq.sv
// Handshaked golden evaluator for Verilog binary operators under context-width and
// signedness rules; DIV/MOD/POW run on the shared iterative engine.
module vh_expr_eval_seq
  import vh_expr_pkg::*;
#(
  parameter int unsigned A_WIDTH  = 4,
  parameter int unsigned B_WIDTH  = 4,
  parameter int unsigned Y_WIDTH  = 8,
  parameter bit          A_SIGNED = 1'b0,
  parameter bit          B_SIGNED = 1'b0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [3:0]         op_i,
  input  logic [A_WIDTH-1:0] a_i,
  input  logic [B_WIDTH-1:0] b_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [Y_WIDTH-1:0] y_o,
  output logic               y_undef_o
);

  localparam int unsigned W  = max3(A_WIDTH, B_WIDTH, Y_WIDTH);
  localparam int unsigned CW = (A_WIDTH > B_WIDTH) ? A_WIDTH : B_WIDTH;
  localparam bit          Sgn = A_SIGNED && B_SIGNED;

  state_t             state_q;
  logic               in_ready_q, out_valid_q, undef_q;
  logic [Y_WIDTH-1:0] y_q;
  logic [3:0]         op_q;
  logic qneg_q, rneg_q, bz_q, pneg_q, az_q, aone_q, am1_q, bodd_q;

  logic [W-1:0]  a_w, b_w, a_sh, mag_a, mag_b, sc_r;
  logic [CW-1:0] a_c, b_c;
  logic          sa, sb, lt, sc_undef, iter_op, pow_op, eng_start;
  logic          eng_done;
  logic [W-1:0]  eng_quot, eng_rem, eng_pow, q_s, r_s;
  logic [Y_WIDTH-1:0] fix_y;
  logic               fix_undef;

  // Operand extension: arithmetic/bitwise/compare use joint signedness, shifts and POW use A_SIGNED.
  always_comb begin
    if (Sgn) begin
      a_w = W'($signed(a_i));
      b_w = W'($signed(b_i));
      a_c = CW'($signed(a_i));
      b_c = CW'($signed(b_i));
      lt  = $signed(a_c) < $signed(b_c);
    end else begin
      a_w = W'(a_i);
      b_w = W'(b_i);
      a_c = CW'(a_i);
      b_c = CW'(b_i);
      lt  = a_c < b_c;
    end
    if (A_SIGNED) a_sh = W'($signed(a_i));
    else          a_sh = W'(a_i);
    sa    = Sgn && a_i[A_WIDTH-1];
    sb    = Sgn && b_i[B_WIDTH-1];
    mag_a = sa ? -a_w : a_w;
    mag_b = sb ? -b_w : b_w;
  end

  always_comb begin
    sc_r     = '0;
    sc_undef = 1'b0;
    case (op_i)
      OpAdd:  sc_r = a_w + b_w;
      OpSub:  sc_r = a_w - b_w;
      OpMul:  sc_r = a_w * b_w;
      OpAnd:  sc_r = a_w & b_w;
      OpOr:   sc_r = a_w | b_w;
      OpXor:  sc_r = a_w ^ b_w;
      OpXnor: sc_r = ~(a_w ^ b_w);
      OpShl:  sc_r = a_sh << b_i;
      OpShr:  sc_r = a_sh >> b_i;
      OpSshr: begin
        if (A_SIGNED) sc_r = $signed(a_sh) >>> b_i;
        else          sc_r = a_sh >> b_i;
      end
      OpLt:   sc_r = W'(lt);
      OpEq:   sc_r = W'(a_c == b_c);
      OpDiv, OpMod, OpPow: sc_r = '0;
      default: sc_undef = 1'b1;
    endcase
  end

  assign pow_op    = (op_i == OpPow);
  assign iter_op   = (op_i == OpDiv) || (op_i == OpMod) || pow_op;
  assign eng_start = (state_q == StIdle) && in_valid_i && iter_op;

  vh_iter_engine #(
    .W  (W),
    .EW (B_WIDTH)
  ) u_engine (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (eng_start),
    .pow_i   (pow_op),
    .opa_i   (pow_op ? a_sh : mag_a),
    .opb_i   (mag_b),
    .exp_i   (b_i),
    .done_o  (eng_done),
    .quot_o  (eng_quot),
    .rem_o   (eng_rem),
    .pow_o   (eng_pow)
  );

  // Sign fix-up and undef resolution applied on the engine's final step.
  always_comb begin
    fix_y     = '0;
    fix_undef = 1'b0;
    q_s       = qneg_q ? -eng_quot : eng_quot;
    r_s       = rneg_q ? -eng_rem : eng_rem;
    case (op_q)
      OpDiv: begin
        if (bz_q) fix_undef = 1'b1;
        else      fix_y = q_s[Y_WIDTH-1:0];
      end
      OpMod: begin
        if (bz_q) fix_undef = 1'b1;
        else      fix_y = r_s[Y_WIDTH-1:0];
      end
      OpPow: begin
        if (!pneg_q)    fix_y = eng_pow[Y_WIDTH-1:0];
        else if (az_q)  fix_undef = 1'b1;
        else if (aone_q) fix_y = Y_WIDTH'(1);
        else if (am1_q) fix_y = bodd_q ? '1 : Y_WIDTH'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      undef_q     <= 1'b0;
      op_q        <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      bz_q        <= 1'b0;
      pneg_q      <= 1'b0;
      az_q        <= 1'b0;
      aone_q      <= 1'b0;
      am1_q       <= 1'b0;
      bodd_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            op_q       <= op_i;
            qneg_q     <= sa ^ sb;
            rneg_q     <= sa;
            bz_q       <= (b_i == '0);
            pneg_q     <= B_SIGNED && b_i[B_WIDTH-1];
            az_q       <= (a_i == '0);
            aone_q     <= (a_i == A_WIDTH'(1));
            am1_q      <= A_SIGNED && (&a_i);
            bodd_q     <= b_i[0];
            in_ready_q <= 1'b0;
            if (iter_op) begin
              state_q <= StCalc;
            end else begin
              state_q     <= StDone;
              out_valid_q <= 1'b1;
              y_q         <= sc_undef ? '0 : sc_r[Y_WIDTH-1:0];
              undef_q     <= sc_undef;
            end
          end
        end
        StCalc: begin
          if (eng_done) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
            y_q         <= fix_y;
            undef_q     <= fix_undef;
          end
        end
        StDone: begin
          if (out_ready_i) begin
            state_q     <= StIdle;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign y_o         = y_q;
  assign y_undef_o   = undef_q;

endmodule

// File: tb/tb_vh_expr_eval_seq.sv
// Bench for vh_expr_eval_seq: three signedness configurations, directed table,
// handshake/reset sequences and random traffic against an integer reference model.
module tb_vh_expr_eval_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid  [3];
  logic       in_ready  [3];
  logic [3:0] op        [3];
  logic [3:0] a         [3];
  logic [3:0] b         [3];
  logic       out_valid [3];
  logic       out_ready [3];
  logic [7:0] y         [3];
  logic       y_undef   [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // dut0: unsigned/unsigned, dut1: signed/signed, dut2: signed a, unsigned b
  vh_expr_eval_seq #(.A_WIDTH(4), .B_WIDTH(4), .Y_WIDTH(8), .A_SIGNED(1'b0), .B_SIGNED(1'b0))
  u_dut0 (.clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
          .op_i(op[0]), .a_i(a[0]), .b_i(b[0]), .out_valid_o(out_valid[0]),
          .out_ready_i(out_ready[0]), .y_o(y[0]), .y_undef_o(y_undef[0]));

  vh_expr_eval_seq #(.A_WIDTH(4), .B_WIDTH(4), .Y_WIDTH(8), .A_SIGNED(1'b1), .B_SIGNED(1'b1))
  u_dut1 (.clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
          .op_i(op[1]), .a_i(a[1]), .b_i(b[1]), .out_valid_o(out_valid[1]),
          .out_ready_i(out_ready[1]), .y_o(y[1]), .y_undef_o(y_undef[1]));

  vh_expr_eval_seq #(.A_WIDTH(4), .B_WIDTH(4), .Y_WIDTH(8), .A_SIGNED(1'b1), .B_SIGNED(1'b0))
  u_dut2 (.clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]),
          .op_i(op[2]), .a_i(a[2]), .b_i(b[2]), .out_valid_o(out_valid[2]),
          .out_ready_i(out_ready[2]), .y_o(y[2]), .y_undef_o(y_undef[2]));

  typedef struct {
    int         d;
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] y;
    logic       u;
    int         lat;
  } vec_t;

  vec_t tbl [16];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int sx4(input logic [3:0] v);
    return v[3] ? int'(v) - 16 : int'(v);
  endfunction

  // Integer reference: 8-bit context, 4-bit operands.
  function automatic void model(input int d, input logic [3:0] o, input logic [3:0] ia,
                                input logic [3:0] ib, output logic [7:0] ey,
                                output logic eu, output int lat);
    bit as, bs, sg;
    int av, bv, ash, r;
    as  = (d != 0);
    bs  = (d == 1);
    sg  = as && bs;
    av  = sg ? sx4(ia) : int'(ia);
    bv  = sg ? sx4(ib) : int'(ib);
    ash = as ? sx4(ia) : int'(ia);
    eu  = 1'b0;
    r   = 0;
    lat = 1;
    case (o)
      4'd0:  r = av + bv;
      4'd1:  r = av - bv;
      4'd2:  r = av * bv;
      4'd3:  begin lat = 9; if (bv == 0) eu = 1'b1; else r = av / bv; end
      4'd4:  begin lat = 9; if (bv == 0) eu = 1'b1; else r = av % bv; end
      4'd5: begin
        lat = 5;
        if (bs && ib[3]) begin
          if (ash == 0)              eu = 1'b1;
          else if (ash == 1)         r = 1;
          else if (as && ash == -1)  r = ib[0] ? -1 : 1;
          else                       r = 0;
        end else begin
          r = 1;
          for (int i = 0; i < int'(ib); i++) r = (r * ash) & 255;
        end
      end
      4'd6:  r = ash << ib;
      4'd7:  r = (ash & 255) >> ib;
      4'd8:  r = as ? (ash >>> ib) : ((ash & 255) >> ib);
      4'd9:  r = av & bv;
      4'd10: r = av | bv;
      4'd11: r = av ^ bv;
      4'd12: r = ~(av ^ bv);
      4'd13: r = (av < bv) ? 1 : 0;
      4'd14: r = (av == bv) ? 1 : 0;
      default: eu = 1'b1;
    endcase
    ey = eu ? 8'h00 : r[7:0];
  endfunction

  // Called and returns on a negedge with in_valid low.
  task automatic run_xact(input int d, input logic [3:0] o, input logic [3:0] ia,
                          input logic [3:0] ib, input logic [7:0] ey, input logic eu,
                          input int elat, input string nm);
    int n;
    n = 0;
    while (!in_ready[d] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({nm, ":ready"}, 32'(in_ready[d]), 32'd1);
    op[d] = o; a[d] = ia; b[d] = ib; in_valid[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[d] = 1'b0;
    n = 1;
    while (!out_valid[d] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({nm, ":lat"}, 32'(n), 32'(elat));
    check({nm, ":y"}, 32'(y[d]), 32'(ey));
    check({nm, ":undef"}, 32'(y_undef[d]), 32'(eu));
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
  endtask

  initial begin
    logic [7:0] ey;
    logic       eu;
    int         lat, d;
    logic [3:0] o, ia, ib;
    logic       ghost;

    tbl[0]  = '{0, 4'd0,  4'hF, 4'h1, 8'h10, 1'b0, 1};
    tbl[1]  = '{1, 4'd13, 4'hF, 4'h1, 8'h01, 1'b0, 1};
    tbl[2]  = '{2, 4'd13, 4'hF, 4'h1, 8'h00, 1'b0, 1};
    tbl[3]  = '{1, 4'd6,  4'hF, 4'h3, 8'hF8, 1'b0, 1};
    tbl[4]  = '{0, 4'd6,  4'hF, 4'h3, 8'h78, 1'b0, 1};
    tbl[5]  = '{1, 4'd5,  4'h0, 4'hF, 8'h00, 1'b1, 5};
    tbl[6]  = '{1, 4'd5,  4'hF, 4'hD, 8'hFF, 1'b0, 5};
    tbl[7]  = '{1, 4'd5,  4'hE, 4'hE, 8'h00, 1'b0, 5};
    tbl[8]  = '{1, 4'd5,  4'hD, 4'h3, 8'hE5, 1'b0, 5};
    tbl[9]  = '{0, 4'd3,  4'h9, 4'h0, 8'h00, 1'b1, 9};
    tbl[10] = '{1, 4'd3,  4'h9, 4'h2, 8'hFD, 1'b0, 9};
    tbl[11] = '{0, 4'd15, 4'h1, 4'h1, 8'h00, 1'b1, 1};
    tbl[12] = '{1, 4'd8,  4'h8, 4'h2, 8'hFE, 1'b0, 1};
    tbl[13] = '{1, 4'd4,  4'h9, 4'h2, 8'hFF, 1'b0, 9};
    tbl[14] = '{2, 4'd8,  4'hF, 4'h8, 8'hFF, 1'b0, 1};
    tbl[15] = '{0, 4'd6,  4'h1, 4'h8, 8'h00, 1'b0, 1};

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0; out_ready[i] = 1'b0; op[i] = '0; a[i] = '0; b[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst%0d:in_ready", i), 32'(in_ready[i]), 32'd1);
      check($sformatf("rst%0d:out_valid", i), 32'(out_valid[i]), 32'd0);
      check($sformatf("rst%0d:y", i), 32'(y[i]), 32'd0);
      check($sformatf("rst%0d:undef", i), 32'(y_undef[i]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++)
      run_xact(tbl[i].d, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].y, tbl[i].u, tbl[i].lat,
               $sformatf("vec%0d", i));

    // Back-pressure: result held, new requests ignored.
    op[0] = 4'd2; a[0] = 4'd3; b[0] = 4'd5; in_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("hold:valid", 32'(out_valid[0]), 32'd1);
    op[0] = 4'd0; a[0] = 4'h1; b[0] = 4'h1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("hold%0d:y", i), 32'(y[0]), 32'h0F);
      check($sformatf("hold%0d:in_ready", i), 32'(in_ready[0]), 32'd0);
      check($sformatf("hold%0d:valid", i), 32'(out_valid[0]), 32'd1);
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    check("hold:release_ready", 32'(in_ready[0]), 32'd1);
    check("hold:release_valid", 32'(out_valid[0]), 32'd0);
    @(negedge clk);
    check("hold:no_ghost", 32'(out_valid[0]), 32'd0);

    // Asynchronous reset while a divide is in flight.
    op[1] = 4'd3; a[1] = 4'h9; b[1] = 4'h2; in_valid[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[1] = 1'b0;
    repeat (2) @(negedge clk);
    check("calc:in_ready", 32'(in_ready[1]), 32'd0);
    rst = 1'b1;
    #1;
    check("arst:in_ready", 32'(in_ready[1]), 32'd1);
    check("arst:out_valid", 32'(out_valid[1]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ghost = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid[1]) ghost = 1'b1;
    end
    check("arst:discarded", 32'(ghost), 32'd0);
    run_xact(1, 4'd3, 4'h9, 4'h2, 8'hFD, 1'b0, 9, "arst:redo");

    for (int i = 0; i < 300; i++) begin
      d  = int'($urandom_range(0, 2));
      o  = 4'($urandom_range(0, 15));
      ia = 4'($urandom_range(0, 15));
      ib = 4'($urandom_range(0, 15));
      model(d, o, ia, ib, ey, eu, lat);
      run_xact(d, o, ia, ib, ey, eu, lat,
               $sformatf("rnd%0d d%0d op%0d a%0h b%0h", i, d, o, ia, ib));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
